// File: rtl/pio_edge_poller.sv
// Avalon-MM initiator that polls a PIO edge-capture register, clears any captured
// edges, samples the live level and hands both out as one valid/ready event.
module pio_edge_poller #(
   parameter int unsigned WIDTH     = 10,
   parameter int unsigned POLL_DIV  = 1000,
   parameter int unsigned CAP_ADDR  = 3,
   parameter int unsigned DATA_ADDR = 0,
   parameter logic [15:0] CNT_INIT  = 16'h0000  // test hook: ev_count value after reset
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   output logic [1:0]       address,
   output logic             chipselect,
   output logic             write_n,
   output logic [31:0]      writedata,
   input  logic [31:0]      readdata,
   output logic             ev_valid,
   input  logic             ev_ready,
   output logic [WIDTH-1:0] ev_capture,
   output logic [WIDTH-1:0] ev_level,
   output logic [15:0]      ev_count
);

   localparam logic [15:0] LP_RELOAD = 16'(POLL_DIV - 1);
   localparam logic [1:0]  LP_CAP    = 2'(CAP_ADDR);
   localparam logic [1:0]  LP_DAT    = 2'(DATA_ADDR);

   typedef enum logic [2:0] {
      S_WAIT, S_RD_CAP, S_LAT_CAP, S_CLR, S_RD_DAT, S_LAT_DAT, S_OUT
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [15:0]      r_cnt, w_cnt_nxt;
   logic             r_cs, w_cs_nxt;
   logic             r_wn, w_wn_nxt;
   logic [1:0]       r_addr, w_addr_nxt;
   logic [WIDTH-1:0] r_cap, r_lvl;
   logic [15:0]      r_count;
   logic             w_accept;
   logic             w_unused_rd;

   assign w_unused_rd = &{1'b0, readdata[31:WIDTH]};
   assign w_accept    = (r_state == S_OUT) && ev_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_WAIT: begin
            if (r_cnt != 16'd0)  w_cnt_nxt   = r_cnt - 16'd1;
            else if (enable)     w_state_nxt = S_RD_CAP;
         end
         S_RD_CAP:  w_state_nxt = S_LAT_CAP;
         S_LAT_CAP: begin
            if (readdata[WIDTH-1:0] == '0) begin
               w_state_nxt = S_WAIT;
               w_cnt_nxt   = LP_RELOAD;
            end else begin
               w_state_nxt = S_CLR;
            end
         end
         S_CLR:     w_state_nxt = S_RD_DAT;
         S_RD_DAT:  w_state_nxt = S_LAT_DAT;
         S_LAT_DAT: w_state_nxt = S_OUT;
         S_OUT: begin
            if (ev_ready) begin
               w_state_nxt = S_WAIT;
               w_cnt_nxt   = LP_RELOAD;
            end
         end
         default: begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = LP_RELOAD;
         end
      endcase
   end

   // Bus outputs are registered from the next state so they line up with the state cycle.
   always_comb begin
      w_cs_nxt   = 1'b0;
      w_wn_nxt   = 1'b1;
      w_addr_nxt = r_addr;
      case (w_state_nxt)
         S_RD_CAP: begin w_cs_nxt = 1'b1; w_addr_nxt = LP_CAP; end
         S_CLR:    begin w_cs_nxt = 1'b1; w_wn_nxt = 1'b0; w_addr_nxt = LP_CAP; end
         S_RD_DAT: begin w_cs_nxt = 1'b1; w_addr_nxt = LP_DAT; end
         default:  ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_WAIT;
         r_cnt   <= LP_RELOAD;
         r_cs    <= 1'b0;
         r_wn    <= 1'b1;
         r_addr  <= 2'd0;
         r_cap   <= '0;
         r_lvl   <= '0;
         r_count <= CNT_INIT;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_cs    <= w_cs_nxt;
         r_wn    <= w_wn_nxt;
         r_addr  <= w_addr_nxt;
         if (r_state == S_LAT_CAP) r_cap <= readdata[WIDTH-1:0];
         if (r_state == S_LAT_DAT) r_lvl <= readdata[WIDTH-1:0];
         if (w_accept && (r_count != 16'hFFFF)) r_count <= r_count + 16'd1;
      end
   end

   assign address    = r_addr;
   assign chipselect = r_cs;
   assign write_n    = r_wn;
   assign writedata  = 32'd0;
   assign ev_valid   = (r_state == S_OUT);
   assign ev_capture = r_cap;
   assign ev_level   = r_lvl;
   assign ev_count   = r_count;

endmodule

// File: tb/tb_pio_edge_poller.sv
// Directed bench for pio_edge_poller: POLL_DIV=4 main instance plus a preloaded
// POLL_DIV=1 instance for counter saturation.
module tb_pio_edge_poller;

   logic        clk = 1'b0;
   logic        reset, enable, ev_ready;
   logic [31:0] readdata;
   logic [1:0]  address;
   logic        chipselect, write_n, ev_valid;
   logic [31:0] writedata;
   logic [9:0]  ev_capture, ev_level;
   logic [15:0] ev_count;

   logic        ev_ready2;
   logic [31:0] readdata2;
   logic [1:0]  address2;
   logic        chipselect2, write_n2, ev_valid2;
   logic [31:0] writedata2;
   logic [9:0]  ev_capture2, ev_level2;
   logic [15:0] ev_count2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pio_edge_poller #(.WIDTH(10), .POLL_DIV(4), .CAP_ADDR(3), .DATA_ADDR(0)) dut (
      .clk(clk), .reset(reset), .enable(enable), .address(address),
      .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
      .readdata(readdata), .ev_valid(ev_valid), .ev_ready(ev_ready),
      .ev_capture(ev_capture), .ev_level(ev_level), .ev_count(ev_count));

   pio_edge_poller #(.WIDTH(10), .POLL_DIV(1), .CNT_INIT(16'hFFFD)) dut_sat (
      .clk(clk), .reset(reset), .enable(1'b1), .address(address2),
      .chipselect(chipselect2), .write_n(write_n2), .writedata(writedata2),
      .readdata(readdata2), .ev_valid(ev_valid2), .ev_ready(ev_ready2),
      .ev_capture(ev_capture2), .ev_level(ev_level2), .ev_count(ev_count2));

   task automatic tick;
      @(posedge clk); #1;
   endtask

   // Advance to the next capture-register read (cycle T); no comparison here.
   task automatic wait_rdcap(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (chipselect && write_n && address == 2'd3) begin ok = 1'b1; return; end
      end
   endtask

   // From cycle T, feed capture then level data; returns in cycle T+5.
   task automatic run_event(input logic [31:0] cap, input logic [31:0] lvl);
      tick(); readdata = cap;
      tick(); readdata = 32'd0;
      tick();
      tick(); readdata = lvl;
      tick(); readdata = 32'd0;
   endtask

   task automatic test_reset;
      reset = 1'b1; enable = 1'b1; ev_ready = 1'b0; readdata = 32'd0;
      ev_ready2 = 1'b0; readdata2 = 32'd1;
      repeat (3) tick();
      checks++;
      if ({chipselect, write_n, address, writedata} !== {1'b0, 1'b1, 2'd0, 32'd0}) begin
         errors++; $display("FAIL reset_bus: cs=%b wn=%b addr=%0d wd=%h, want 0 1 0 0",
                            chipselect, write_n, address, writedata);
      end
      checks++;
      if ({ev_valid, ev_capture, ev_level, ev_count} !== {1'b0, 10'd0, 10'd0, 16'd0}) begin
         errors++; $display("FAIL reset_ev: v=%b cap=%h lvl=%h cnt=%h, want all 0",
                            ev_valid, ev_capture, ev_level, ev_count);
      end
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (chipselect !== 1'b0) begin
            errors++; $display("FAIL reset_first_wait: cycle %0d cs=%b want 0", i, chipselect);
         end
         tick();
      end
      checks++;
      if ({chipselect, write_n, address} !== {1'b1, 1'b1, 2'd3}) begin
         errors++; $display("FAIL reset_first_poll: cs=%b wn=%b addr=%0d want 1 1 3",
                            chipselect, write_n, address);
      end
   endtask

   task automatic test_idle;
      int last = 0;
      int pulses = 0;
      for (int i = 1; i <= 30; i++) begin
         tick();
         checks++;
         if (write_n !== 1'b1 || ev_valid !== 1'b0) begin
            errors++; $display("FAIL idle_quiet: cycle %0d wn=%b v=%b want 1 0", i, write_n, ev_valid);
         end
         if (chipselect) begin
            pulses++;
            checks++;
            if (address !== 2'd3 || i - last != 6) begin
               errors++; $display("FAIL idle_period: addr=%0d gap=%0d want 3 6", address, i - last);
            end
            last = i;
         end
      end
      checks++;
      if (pulses != 5) begin
         errors++; $display("FAIL idle_count: polls=%0d want 5", pulses);
      end
   endtask

   task automatic test_single;
      bit ok;
      ev_ready = 1'b1;
      wait_rdcap(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL single_timeout: no poll seen, want one"); return; end
      tick(); readdata = 32'h004;
      checks++;
      if (chipselect !== 1'b0) begin errors++; $display("FAIL single_latcap: cs=%b want 0", chipselect); end
      tick(); readdata = 32'd0;
      checks++;
      if ({chipselect, write_n, address, writedata} !== {1'b1, 1'b0, 2'd3, 32'd0}) begin
         errors++; $display("FAIL single_clr: cs=%b wn=%b addr=%0d wd=%h want 1 0 3 0",
                            chipselect, write_n, address, writedata);
      end
      tick();
      checks++;
      if ({chipselect, write_n, address} !== {1'b1, 1'b1, 2'd0}) begin
         errors++; $display("FAIL single_rddat: cs=%b wn=%b addr=%0d want 1 1 0",
                            chipselect, write_n, address);
      end
      tick(); readdata = 32'h3F0;
      checks++;
      if ({chipselect, address, ev_valid} !== {1'b0, 2'd0, 1'b0}) begin
         errors++; $display("FAIL single_latdat: cs=%b addr=%0d v=%b want 0 0 0",
                            chipselect, address, ev_valid);
      end
      tick(); readdata = 32'd0;
      checks++;
      if ({ev_valid, ev_capture, ev_level, ev_count} !== {1'b1, 10'h004, 10'h3F0, 16'd0}) begin
         errors++; $display("FAIL single_event: v=%b cap=%h lvl=%h cnt=%0d want 1 004 3f0 0",
                            ev_valid, ev_capture, ev_level, ev_count);
      end
      tick();
      checks++;
      if ({ev_valid, ev_count} !== {1'b0, 16'd1}) begin
         errors++; $display("FAIL single_accept: v=%b cnt=%0d want 0 1", ev_valid, ev_count);
      end
   endtask

   task automatic test_backpressure;
      bit ok;
      ev_ready = 1'b0;
      wait_rdcap(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL bp_timeout: no poll seen, want one"); return; end
      run_event(32'h2A5, 32'h155);
      readdata = 32'hFFFF_FFFF;
      for (int i = 0; i < 20; i++) begin
         checks++;
         if ({ev_valid, ev_capture, ev_level, chipselect} !== {1'b1, 10'h2A5, 10'h155, 1'b0}) begin
            errors++; $display("FAIL bp_hold: cycle %0d v=%b cap=%h lvl=%h cs=%b want 1 2a5 155 0",
                               i, ev_valid, ev_capture, ev_level, chipselect);
         end
         tick();
      end
      ev_ready = 1'b1; readdata = 32'd0;
      tick();
      checks++;
      if ({ev_valid, ev_count, chipselect} !== {1'b0, 16'd2, 1'b0}) begin
         errors++; $display("FAIL bp_accept: v=%b cnt=%0d cs=%b want 0 2 0", ev_valid, ev_count, chipselect);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (chipselect !== 1'b0) begin errors++; $display("FAIL bp_wait: cs=%b want 0", chipselect); end
      end
      tick();
      checks++;
      if ({chipselect, write_n, address} !== {1'b1, 1'b1, 2'd3}) begin
         errors++; $display("FAIL bp_next_poll: cs=%b wn=%b addr=%0d want 1 1 3", chipselect, write_n, address);
      end
   endtask

   task automatic test_upper_bits;
      bit ok;
      ev_ready = 1'b1;
      wait_rdcap(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL upper_timeout: no poll seen, want one"); return; end
      run_event(32'hFFFF_F801, 32'hFFFF_F8AB);
      checks++;
      if ({ev_valid, ev_capture, ev_level} !== {1'b1, 10'h001, 10'h0AB}) begin
         errors++; $display("FAIL upper_bits: v=%b cap=%h lvl=%h want 1 001 0ab", ev_valid, ev_capture, ev_level);
      end
      tick();
      checks++;
      if (ev_count !== 16'd3) begin errors++; $display("FAIL upper_count: cnt=%0d want 3", ev_count); end
   endtask

   task automatic test_enable;
      int seen = 0;
      enable = 1'b0; readdata = 32'd0;
      repeat (10) tick();
      for (int i = 0; i < 100; i++) begin
         tick();
         if (chipselect) seen++;
      end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL enable_off: %0d chipselect cycles, want 0", seen); end
      enable = 1'b1;
      tick();
      checks++;
      if ({chipselect, write_n, address} !== {1'b1, 1'b1, 2'd3}) begin
         errors++; $display("FAIL enable_resume: cs=%b wn=%b addr=%0d want 1 1 3", chipselect, write_n, address);
      end
   endtask

   task automatic test_reset_in_clr;
      bit ok;
      ev_ready = 1'b1;
      wait_rdcap(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rstclr_timeout: no poll seen, want one"); return; end
      tick(); readdata = 32'h3FF;
      tick(); readdata = 32'd0;
      checks++;
      if ({chipselect, write_n} !== {1'b1, 1'b0}) begin
         errors++; $display("FAIL rstclr_inclr: cs=%b wn=%b want 1 0", chipselect, write_n);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({chipselect, write_n, address, writedata, ev_valid, ev_capture, ev_level, ev_count}
          !== {1'b0, 1'b1, 2'd0, 32'd0, 1'b0, 10'd0, 10'd0, 16'd0}) begin
         errors++; $display("FAIL rstclr_outputs: cs=%b wn=%b addr=%0d v=%b cap=%h lvl=%h cnt=%0d want reset values",
                            chipselect, write_n, address, ev_valid, ev_capture, ev_level, ev_count);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (chipselect !== 1'b0) begin
            errors++; $display("FAIL rstclr_no_rddat: cs=%b addr=%0d want cs 0", chipselect, address);
         end
      end
      tick();
      checks++;
      if ({chipselect, write_n, address} !== {1'b1, 1'b1, 2'd3}) begin
         errors++; $display("FAIL rstclr_repoll: cs=%b wn=%b addr=%0d want 1 1 3", chipselect, write_n, address);
      end
   endtask

   task automatic test_saturation;
      logic [15:0] exp = 16'hFFFD;
      int accepts = 0;
      checks++;
      if (ev_count2 !== 16'hFFFD) begin errors++; $display("FAIL sat_preload: cnt=%h want fffd", ev_count2); end
      ev_ready2 = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if (ev_valid2) begin
            accepts++;
            exp = (exp == 16'hFFFF) ? exp : exp + 16'd1;
         end
         tick();
         checks++;
         if (ev_count2 !== exp) begin
            errors++; $display("FAIL sat_count: cycle %0d cnt=%h want %h", i, ev_count2, exp);
         end
      end
      checks++;
      if (accepts < 4 || ev_count2 !== 16'hFFFF) begin
         errors++; $display("FAIL sat_final: accepts=%0d cnt=%h want >=4 ffff", accepts, ev_count2);
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_single();
      test_backpressure();
      test_upper_bits();
      test_enable();
      test_reset_in_clr();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
